// File: rtl/arm_reg_file_if.sv
// Write-port and PC-control bundle feeding arm_reg_file.
// The pipeline side drives it (master); the register file consumes it (slave).
interface arm_reg_file_if #(
  parameter int DATA_W = 32
);
  logic              we_a;
  logic [3:0]        waddr_a;
  logic [DATA_W-1:0] wdata_a;
  logic              we_b;
  logic [3:0]        waddr_b;
  logic [DATA_W-1:0] wdata_b;
  logic              pc_inc;
  logic              pc_load;
  logic [DATA_W-1:0] pc_target;
  logic              stall;

  modport master (
    output we_a, waddr_a, wdata_a,
    output we_b, waddr_b, wdata_b,
    output pc_inc, pc_load, pc_target, stall
  );

  modport slave (
    input we_a, waddr_a, wdata_a,
    input we_b, waddr_b, wdata_b,
    input pc_inc, pc_load, pc_target, stall
  );
endinterface

// File: rtl/arm_reg_file.sv
// 16 x DATA_W ARM register file with two write ports and R15 program counter.
// Optional REGFILE_BYPASS_EN: outputs show pending data-port writes combinationally.
module arm_reg_file #(
  parameter int              DATA_W   = 32,
  parameter int unsigned     PC_STEP  = 4,
  parameter logic [DATA_W-1:0] PC_RESET = 32'h0000_0000,
  parameter logic [DATA_W-1:0] SP_RESET = 32'h0000_1000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  arm_reg_file_if.slave     bus,
  output logic [DATA_W-1:0] o_R0,
  output logic [DATA_W-1:0] o_R1,
  output logic [DATA_W-1:0] o_R2,
  output logic [DATA_W-1:0] o_R3,
  output logic [DATA_W-1:0] o_R4,
  output logic [DATA_W-1:0] o_R5,
  output logic [DATA_W-1:0] o_R6,
  output logic [DATA_W-1:0] o_R7,
  output logic [DATA_W-1:0] o_R8,
  output logic [DATA_W-1:0] o_R9,
  output logic [DATA_W-1:0] o_R10,
  output logic [DATA_W-1:0] o_R11,
  output logic [DATA_W-1:0] o_R12,
  output logic [DATA_W-1:0] o_R13,
  output logic [DATA_W-1:0] o_R14,
  output logic [DATA_W-1:0] o_R15,
  output logic [DATA_W-1:0] o_pc,
  output logic              o_wr_conflict
);

  logic [DATA_W-1:0] r_regs [16];
  logic              r_wr_conflict;
  logic [DATA_W-1:0] w_next [16];
  logic [DATA_W-1:0] w_view [16];
  logic              w_a_pc;
  logic              w_b_pc;
  logic              w_conflict;

  assign w_a_pc     = bus.we_a && (bus.waddr_a == 4'd15);
  assign w_b_pc     = bus.we_b && (bus.waddr_b == 4'd15);
  assign w_conflict = bus.we_a && bus.we_b && (bus.waddr_a == bus.waddr_b);

  always_comb begin
    for (int i = 0; i < 15; i++) begin
      w_next[i] = r_regs[i];
      if (bus.we_a && (bus.waddr_a == 4'(i)))
        w_next[i] = bus.wdata_a;
      else if (bus.we_b && (bus.waddr_b == 4'(i)))
        w_next[i] = bus.wdata_b;
    end
    // Stall freezes only branch/increment; data-port writes to R15 still land.
    w_next[15] = r_regs[15];
    if (bus.stall && !w_a_pc && !w_b_pc)
      w_next[15] = r_regs[15];
    else if (bus.pc_load && !bus.stall)
      w_next[15] = bus.pc_target;
    else if (w_a_pc)
      w_next[15] = bus.wdata_a;
    else if (w_b_pc)
      w_next[15] = bus.wdata_b;
    else if (bus.pc_inc && !bus.stall)
      w_next[15] = r_regs[15] + DATA_W'(PC_STEP);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 16; i++)
        r_regs[i] <= '0;
      r_regs[13]    <= SP_RESET;
      r_regs[15]    <= PC_RESET;
      r_wr_conflict <= 1'b0;
    end else begin
      for (int i = 0; i < 16; i++)
        r_regs[i] <= w_next[i];
      r_wr_conflict <= w_conflict;
    end
  end

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      w_view[i] = r_regs[i];
`ifdef REGFILE_BYPASS_EN
      if (bus.we_a && (bus.waddr_a == 4'(i)))
        w_view[i] = bus.wdata_a;
      else if (bus.we_b && (bus.waddr_b == 4'(i)))
        w_view[i] = bus.wdata_b;
`endif
    end
  end

  assign o_R0          = w_view[0];
  assign o_R1          = w_view[1];
  assign o_R2          = w_view[2];
  assign o_R3          = w_view[3];
  assign o_R4          = w_view[4];
  assign o_R5          = w_view[5];
  assign o_R6          = w_view[6];
  assign o_R7          = w_view[7];
  assign o_R8          = w_view[8];
  assign o_R9          = w_view[9];
  assign o_R10         = w_view[10];
  assign o_R11         = w_view[11];
  assign o_R12         = w_view[12];
  assign o_R13         = w_view[13];
  assign o_R14         = w_view[14];
  assign o_R15         = w_view[15];
  assign o_pc          = w_view[15];
  assign o_wr_conflict = r_wr_conflict;

endmodule

// File: tb/tb_arm_reg_file.sv
// Directed self-checking bench for arm_reg_file (expected values hand-computed).
module tb_arm_reg_file;

  logic        clk_sys;
  logic        rst_n;
  logic [31:0] w_r0, w_r1, w_r2, w_r3, w_r4, w_r5, w_r6, w_r7;
  logic [31:0] w_r8, w_r9, w_r10, w_r11, w_r12, w_r13, w_r14, w_r15;
  logic [31:0] w_pc;
  logic        w_conf;
  logic [31:0] obs [16];
  int          n_cmp;
  int          n_bad;

  arm_reg_file_if #(.DATA_W(32)) bus ();

  arm_reg_file dut (
    .i_clk(clk_sys), .i_rst_n(rst_n), .bus(bus.slave),
    .o_R0(w_r0), .o_R1(w_r1), .o_R2(w_r2), .o_R3(w_r3),
    .o_R4(w_r4), .o_R5(w_r5), .o_R6(w_r6), .o_R7(w_r7),
    .o_R8(w_r8), .o_R9(w_r9), .o_R10(w_r10), .o_R11(w_r11),
    .o_R12(w_r12), .o_R13(w_r13), .o_R14(w_r14), .o_R15(w_r15),
    .o_pc(w_pc), .o_wr_conflict(w_conf)
  );

  always_comb begin
    obs[0] = w_r0;   obs[1] = w_r1;   obs[2] = w_r2;   obs[3] = w_r3;
    obs[4] = w_r4;   obs[5] = w_r5;   obs[6] = w_r6;   obs[7] = w_r7;
    obs[8] = w_r8;   obs[9] = w_r9;   obs[10] = w_r10; obs[11] = w_r11;
    obs[12] = w_r12; obs[13] = w_r13; obs[14] = w_r14; obs[15] = w_r15;
  end

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.we_a = 0; bus.waddr_a = 0; bus.wdata_a = 0;
    bus.we_b = 0; bus.waddr_b = 0; bus.wdata_b = 0;
    bus.pc_inc = 0; bus.pc_load = 0; bus.pc_target = 0; bus.stall = 0;
  endtask

  // One clock edge, then drop all inputs so outputs reflect flop state only.
  task automatic tick();
    @(posedge clk_sys);
    #1;
    idle();
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 16; i++) begin
      if (i == 13)
        check($sformatf("%s R13", tag), obs[i], 32'h0000_1000);
      else
        check($sformatf("%s R%0d", tag, i), obs[i], 32'h0);
    end
    check({tag, " pc"}, w_pc, 32'h0);
    check({tag, " conflict"}, {31'b0, w_conf}, 32'h0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle();
    rst_n = 1'b0;
    // Write pending across a reset edge must be discarded.
    bus.we_a = 1; bus.waddr_a = 4'd2; bus.wdata_a = 32'hAAAA_5555;
    @(posedge clk_sys);
    #2;
    idle();
    #1;
    check_reset_state("reset");
    @(negedge clk_sys);
    rst_n = 1'b1;

    // Write latency on R3
    bus.we_a = 1; bus.waddr_a = 4'd3; bus.wdata_a = 32'hDEAD_BEEF;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("R3 before edge (bypass)", obs[3], 32'hDEAD_BEEF);
`else
    check("R3 before edge", obs[3], 32'h0);
`endif
    tick();
    check("R3 after edge", obs[3], 32'hDEAD_BEEF);

    // Same-register dual write: A wins, conflict flagged for one cycle
    bus.we_a = 1; bus.waddr_a = 4'd5; bus.wdata_a = 32'h11;
    bus.we_b = 1; bus.waddr_b = 4'd5; bus.wdata_b = 32'h22;
    tick();
    check("R5 A wins", obs[5], 32'h11);
    check("conflict set", {31'b0, w_conf}, 32'h1);
    tick();
    check("conflict clears", {31'b0, w_conf}, 32'h0);
    check("R5 holds", obs[5], 32'h11);

    // Distinct addresses on both ports
    bus.we_a = 1; bus.waddr_a = 4'd7; bus.wdata_a = 32'h7777_0007;
    bus.we_b = 1; bus.waddr_b = 4'd8; bus.wdata_b = 32'h8888_0008;
    tick();
    check("R7 port A", obs[7], 32'h7777_0007);
    check("R8 port B", obs[8], 32'h8888_0008);
    check("no conflict diff addr", {31'b0, w_conf}, 32'h0);
    check("R3 untouched", obs[3], 32'hDEAD_BEEF);

    bus.we_b = 1; bus.waddr_b = 4'd13; bus.wdata_b = 32'h0000_2000;
    bus.we_a = 1; bus.waddr_a = 4'd14; bus.wdata_a = 32'h0000_0ABC;
    tick();
    check("SP write", obs[13], 32'h0000_2000);
    check("LR write", obs[14], 32'h0000_0ABC);
    check("pc untouched", w_pc, 32'h0);

    // PC sequencing and stall
    for (int k = 1; k <= 3; k++) begin
      bus.pc_inc = 1;
      tick();
      check($sformatf("pc inc %0d", k), w_pc, 32'(4 * k));
    end
    for (int k = 0; k < 2; k++) begin
      bus.pc_inc = 1; bus.stall = 1;
      tick();
      check($sformatf("pc stall %0d", k), w_pc, 32'd12);
    end
    bus.pc_load = 1; bus.pc_target = 32'h0000_0500; bus.stall = 1;
    tick();
    check("stall blocks load", w_pc, 32'd12);
    tick();
    check("pc idle hold", w_pc, 32'd12);

    // PC priority: load over port A over inc
    bus.pc_load = 1; bus.pc_target = 32'h100;
    bus.we_a = 1; bus.waddr_a = 4'd15; bus.wdata_a = 32'h200;
    bus.pc_inc = 1;
    tick();
    check("load beats A", w_pc, 32'h100);
    check("R15 alias", obs[15], 32'h100);
    bus.stall = 1; bus.pc_inc = 1;
    bus.we_b = 1; bus.waddr_b = 4'd15; bus.wdata_b = 32'h300;
    tick();
    check("B write under stall", w_pc, 32'h300);
    bus.we_a = 1; bus.waddr_a = 4'd15; bus.wdata_a = 32'h400;
    bus.we_b = 1; bus.waddr_b = 4'd15; bus.wdata_b = 32'h500;
    bus.pc_inc = 1;
    tick();
    check("A beats B and inc", w_pc, 32'h400);
    check("R15 conflict", {31'b0, w_conf}, 32'h1);

    // Wrap at top of address space
    bus.pc_load = 1; bus.pc_target = 32'hFFFF_FFFC;
    tick();
    check("pc load top", w_pc, 32'hFFFF_FFFC);
    bus.pc_inc = 1;
    tick();
    check("pc wrap", w_pc, 32'h0);
    bus.pc_inc = 1;
    tick();
    check("pc after wrap", w_pc, 32'h4);

    // Asynchronous reset mid-cycle with a write pending
    bus.we_a = 1; bus.waddr_a = 4'd9; bus.wdata_a = 32'h9999_9999;
    bus.we_b = 1; bus.waddr_b = 4'd9; bus.wdata_b = 32'h1234_5678;
    @(negedge clk_sys);
    #2;
    rst_n = 1'b0;
    #1;
    idle();
    #1;
    check_reset_state("async reset");
    @(posedge clk_sys);
    #1;
    check("reset R9 discarded", obs[9], 32'h0);
    @(negedge clk_sys);
    rst_n = 1'b1;
    bus.pc_inc = 1;
    tick();
    check("pc after release", w_pc, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/arm_reg_file.md
Name: arm_reg_file

Overview:
- 16 x 32-bit ARM general register file: R0-R12, SP (R13), LR (R14), PC (R15).
- Sits directly upstream of the ALU operand multiplexers. It drives all sixteen register values in parallel; each operand mux selects one with a 4-bit index.
- Two synchronous write ports: port A for ALU result, port B for load/writeback.
- R15 also acts as the program counter, with auto-increment and branch load.

Parameters:
- DATA_W, 32, register width in bits.
- PC_STEP, 4, PC increment per advancing cycle.
- PC_RESET, 32'h0000_0000, R15 value at reset.
- SP_RESET, 32'h0000_1000, R13 value at reset.

Ports:
- i_clk  input  1  system clock; all state changes on rising edge.
- i_rst_n  input  1  reset, asynchronous assert, active-low.
- i_we_a  input  1  port A write enable (ALU result).
- i_waddr_a  input  4  port A destination register.
- i_wdata_a  input  DATA_W  port A write data.
- i_we_b  input  1  port B write enable (load/writeback).
- i_waddr_b  input  4  port B destination register.
- i_wdata_b  input  DATA_W  port B write data.
- i_pc_inc  input  1  advance PC by PC_STEP this cycle.
- i_pc_load  input  1  branch: load R15 from i_pc_target.
- i_pc_target  input  DATA_W  branch target.
- i_stall  input  1  freeze PC update (inc and load); data writes unaffected.
- o_R0 .. o_R15  output  DATA_W each  current register contents, to ALU operand muxes.
- o_pc  output  DATA_W  alias of o_R15.
- o_wr_conflict  output  1  registered flag: both ports targeted the same register last cycle.

Behaviour:
- Reset (i_rst_n=0, asynchronous, any time, including mid-write):
  - R0-R12 and R14 = 0; R13 = SP_RESET; R15 = PC_RESET; o_wr_conflict = 0.
  - Writes pending in the reset cycle are discarded.
  - Release takes effect on the next rising edge.
- Writes take one cycle: data written at edge N is visible on o_Rx after edge N; no combinational bypass unless the optional feature is enabled.
- Registers R0-R14:
  - Port A write wins over port B write when addresses are equal.
  - Non-targeted registers hold.
- R15 next-state priority, highest first:
  1. i_stall=1 with no data write to R15 -> hold.
  2. i_pc_load=1 and i_stall=0 -> i_pc_target.
  3. Port A writes R15 -> i_wdata_a.
  4. Port B writes R15 -> i_wdata_b.
  5. i_pc_inc=1 and i_stall=0 -> R15 + PC_STEP, modulo 2^DATA_W (0xFFFF_FFFC + 4 = 0x0000_0000).
  6. Otherwise hold.
- Stall versus data writes: data-port writes to R15 still apply during i_stall. Stall only blocks i_pc_load and i_pc_inc.
- o_wr_conflict: registered; set for one cycle after any edge where i_we_a & i_we_b & (i_waddr_a == i_waddr_b), otherwise 0.
- No read ports and no internal FSM beyond the R15 priority logic. All outputs come directly from flops.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: each o_Rx shows the value that will be written at the next edge, combinationally, when a data port targets it. Port A has priority. R15 bypass applies to data-port writes only, not to pc_inc or pc_load. Data is then usable by the ALU in the same cycle as writeback.
- Undefined: outputs are pure flop outputs, with one-cycle write latency.

Test Plan:
- Reset: hold i_rst_n=0 mid-cycle with i_we_a=1 -> all o_R0-o_R12 and o_R14 = 0, o_R13 = 0x0000_1000, o_R15 = 0; write not applied.
- Write latency: i_we_a=1, addr 3, data 0xDEADBEEF at edge N -> o_R3 = 0xDEADBEEF after edge N. Without the macro, o_R3 unchanged before edge N; with REGFILE_BYPASS_EN, o_R3 = 0xDEADBEEF before edge N.
- Dual-port conflict: A writes R5 = 0x11, B writes R5 = 0x22 on the same edge -> o_R5 = 0x11, o_wr_conflict = 1 for one cycle, then 0.
- PC sequencing: i_pc_inc=1 for 3 cycles from 0 -> o_pc = 4, 8, 12. i_stall=1 for 2 cycles -> o_pc holds 12.
- PC priority: i_pc_load=1 (target 0x100), port A writes R15 = 0x200, i_pc_inc=1, same edge -> o_pc = 0x100. Next cycle, with i_stall=1 and port B writing R15 = 0x300 -> o_pc = 0x300.
- Wrap: R15 = 0xFFFF_FFFC, i_pc_inc=1 -> o_pc = 0x0000_0000.
